// File: rtl/timestamp_capture_ctrl.sv
// timestamp_capture_ctrl
// Sequences a timed RX capture into the 4-channel timestamping packer.
// Software arms it with a start time and a beat count. While armed or
// running, the channel enables are frozen so the packer never resets
// mid-burst. ADC beats are gated into the packer's fifo_wr_en.
// Optional feature macro: TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
//   When defined, adds the sticky late_err output. An arm whose start time
//   has already passed (immediate=0) is then sent to ERROR instead of ARMED.
module timestamp_capture_ctrl #(
    parameter int SAMPLE_DATA_WIDTH   = 16,
    parameter int SAMPLES_PER_CHANNEL = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] timestamp,
    input  logic [63:0] start_ts,
    input  logic [31:0] sample_count,
    input  logic        arm,
    input  logic        immediate,
    input  logic        abort,
    input  logic        clear,
    input  logic        enable_in_0,
    input  logic        enable_in_1,
    input  logic        enable_in_2,
    input  logic        enable_in_3,
    output logic        enable_out_0,
    output logic        enable_out_1,
    output logic        enable_out_2,
    output logic        enable_out_3,
    input  logic        adc_valid,
    input  logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] adc_data_0,
    input  logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] adc_data_1,
    input  logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] adc_data_2,
    input  logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] adc_data_3,
    output logic        fifo_wr_en,
    output logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] fifo_wr_data_0,
    output logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] fifo_wr_data_1,
    output logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] fifo_wr_data_2,
    output logic [SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] fifo_wr_data_3,
    input  logic        fifo_wr_overflow,
    output logic [2:0]  state,
    output logic        busy,
    output logic        done,
    output logic        overflow_err,
    output logic        config_err,
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
    output logic        late_err,
`endif
    output logic [31:0] beats_done
);

    localparam int DW = SAMPLE_DATA_WIDTH * SAMPLES_PER_CHANNEL;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t        r_state;
    logic [63:0]   r_start_l;
    logic [31:0]   r_count_l;
    logic          r_imm_l;
    logic [31:0]   r_beats;
    logic          r_ovf_err;
    logic          r_cfg_err;
    logic [3:0]    r_en_out;
    logic          r_wr_en;
    logic [DW-1:0] r_wr_data_0;
    logic [DW-1:0] r_wr_data_1;
    logic [DW-1:0] r_wr_data_2;
    logic [DW-1:0] r_wr_data_3;
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
    logic          r_late_err;
`endif

    logic [3:0] w_en_in;
    logic       w_idle_like;
    logic       w_qual;
    logic       w_pass;

    // beats_done sticks at all-ones in a continuous capture rather than wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_en_in     = {enable_in_3, enable_in_2, enable_in_1, enable_in_0};
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_qual      = r_imm_l || (timestamp >= r_start_l);
    // A beat is forwarded on the first qualifying beat in ARMED and on every beat in RUN;
    // abort suppresses it from the same edge.
    assign w_pass      = !abort && adc_valid &&
                         (((r_state == S_ARMED) && w_qual) || (r_state == S_RUN));

    // Control FSM: arm/abort/clear sequencing, beat counting and error flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_start_l <= 64'd0;
            r_count_l <= 32'd0;
            r_imm_l   <= 1'b0;
            r_beats   <= 32'd0;
            r_ovf_err <= 1'b0;
            r_cfg_err <= 1'b0;
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
            r_late_err <= 1'b0;
`endif
        end else begin
            r_cfg_err <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (arm) begin
                            if (w_en_in == 4'b0000) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_start_l <= start_ts;
                                r_count_l <= sample_count;
                                r_imm_l   <= immediate;
                                r_beats   <= 32'd0;
                                r_ovf_err <= 1'b0;
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
                                if (!immediate && (timestamp > start_ts)) begin
                                    r_late_err <= 1'b1;
                                    r_state    <= S_ERROR;
                                end else begin
                                    r_late_err <= 1'b0;
                                    r_state    <= S_ARMED;
                                end
`else
                                r_state   <= S_ARMED;
`endif
                            end
                        end else if (clear && (r_state != S_IDLE)) begin
                            r_state   <= S_IDLE;
                            r_ovf_err <= 1'b0;
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
                            r_late_err <= 1'b0;
`endif
                        end
                    end
                    S_ARMED: begin
                        if (adc_valid && w_qual) begin
                            r_beats <= 32'd1;
                            r_state <= (r_count_l == 32'd1) ? S_DONE : S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (adc_valid) begin
                            r_beats <= sat_inc(r_beats);
                            if ((r_count_l != 32'd0) && (r_beats + 32'd1 == r_count_l))
                                r_state <= S_DONE;
                        end
                        // Overflow outranks completion; the beat itself still goes out
                        if (fifo_wr_overflow) begin
                            r_ovf_err <= 1'b1;
                            r_state   <= S_ERROR;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Channel enables track the request only while no capture is pending or running
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_en_out <= 4'b0000;
        else if (w_idle_like)
            r_en_out <= w_en_in;
    end

    // Registered beat path to the packer; data holds between passed beats
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_en     <= 1'b0;
            r_wr_data_0 <= '0;
            r_wr_data_1 <= '0;
            r_wr_data_2 <= '0;
            r_wr_data_3 <= '0;
        end else begin
            r_wr_en <= w_pass;
            if (w_pass) begin
                r_wr_data_0 <= adc_data_0;
                r_wr_data_1 <= adc_data_1;
                r_wr_data_2 <= adc_data_2;
                r_wr_data_3 <= adc_data_3;
            end
        end
    end

    assign state          = r_state;
    assign busy           = (r_state == S_ARMED) || (r_state == S_RUN);
    assign done           = (r_state == S_DONE);
    assign overflow_err   = r_ovf_err;
    assign config_err     = r_cfg_err;
    assign beats_done     = r_beats;
    assign enable_out_0   = r_en_out[0];
    assign enable_out_1   = r_en_out[1];
    assign enable_out_2   = r_en_out[2];
    assign enable_out_3   = r_en_out[3];
    assign fifo_wr_en     = r_wr_en;
    assign fifo_wr_data_0 = r_wr_data_0;
    assign fifo_wr_data_1 = r_wr_data_1;
    assign fifo_wr_data_2 = r_wr_data_2;
    assign fifo_wr_data_3 = r_wr_data_3;
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
    assign late_err       = r_late_err;
`endif

endmodule

// File: tb/tb_timestamp_capture_ctrl.sv
// tb_timestamp_capture_ctrl
// Scoreboard bench: every beat expected at the packer is queued when driven
// and compared when fifo_wr_en appears one clock later.
module tb_timestamp_capture_ctrl;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] timestamp, start_ts;
    logic [31:0] sample_count;
    logic arm, immediate, abort, clear;
    logic [3:0] en_in;
    logic enable_out_0, enable_out_1, enable_out_2, enable_out_3;
    logic adc_valid;
    logic [DW-1:0] adc_data_0, adc_data_1, adc_data_2, adc_data_3;
    logic fifo_wr_en;
    logic [DW-1:0] fifo_wr_data_0, fifo_wr_data_1, fifo_wr_data_2, fifo_wr_data_3;
    logic fifo_wr_overflow;
    logic [2:0] state;
    logic busy, done, overflow_err, config_err;
    logic [31:0] beats_done;
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
    logic late_err;
`endif

    timestamp_capture_ctrl #(.SAMPLE_DATA_WIDTH(DW), .SAMPLES_PER_CHANNEL(1)) dut (
        .clk(clk), .resetn(resetn), .timestamp(timestamp), .start_ts(start_ts),
        .sample_count(sample_count), .arm(arm), .immediate(immediate), .abort(abort),
        .clear(clear),
        .enable_in_0(en_in[0]), .enable_in_1(en_in[1]), .enable_in_2(en_in[2]), .enable_in_3(en_in[3]),
        .enable_out_0(enable_out_0), .enable_out_1(enable_out_1),
        .enable_out_2(enable_out_2), .enable_out_3(enable_out_3),
        .adc_valid(adc_valid), .adc_data_0(adc_data_0), .adc_data_1(adc_data_1),
        .adc_data_2(adc_data_2), .adc_data_3(adc_data_3),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data_0(fifo_wr_data_0), .fifo_wr_data_1(fifo_wr_data_1),
        .fifo_wr_data_2(fifo_wr_data_2), .fifo_wr_data_3(fifo_wr_data_3),
        .fifo_wr_overflow(fifo_wr_overflow), .state(state), .busy(busy), .done(done),
        .overflow_err(overflow_err), .config_err(config_err),
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
        .late_err(late_err),
`endif
        .beats_done(beats_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_seen  = 0;
    logic [4*DW-1:0] exp_q[$];

    wire [3:0]      en_out = {enable_out_3, enable_out_2, enable_out_1, enable_out_0};
    wire [4*DW-1:0] wr_all = {fifo_wr_data_3, fifo_wr_data_2, fifo_wr_data_1, fifo_wr_data_0};

    // Channel data derived from the beat's timestamp so each beat is identifiable
    function automatic logic [4*DW-1:0] pat(input logic [63:0] ts);
        logic [15:0] b;
        b = ts[15:0];
        return {b ^ 16'h3333, b ^ 16'h2222, b ^ 16'h1111, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        arm = 1'b0; abort = 1'b0; clear = 1'b0; adc_valid = 1'b0; fifo_wr_overflow = 1'b0;
    endtask

    task automatic set_beat(input logic [63:0] ts, input logic v, input logic pass);
        logic [4*DW-1:0] p;
        p = pat(ts);
        timestamp = ts;
        adc_valid = v;
        {adc_data_3, adc_data_2, adc_data_1, adc_data_0} = p;
        if (pass) exp_q.push_back(p);
    endtask

    // Scoreboard: every fifo_wr_en must match the oldest expected beat
    always @(negedge clk) begin
        if (resetn && fifo_wr_en === 1'b1) begin
            n_seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got fifo_wr_en=1 data=%h, required no beat", wr_all);
            end else begin
                logic [4*DW-1:0] e;
                e = exp_q.pop_front();
                if (wr_all !== e) begin
                    n_fail++;
                    $display("FAIL beat_data: got %h required %h", wr_all, e);
                end
            end
        end
    end

    task automatic test_reset();
        #1;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d required 0", state); end
        n_tests++; if (fifo_wr_en !== 1'b0 || en_out !== 4'b0 || beats_done !== 32'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_outputs: got wr_en=%b en=%b beats=%0d busy=%b required all 0", fifo_wr_en, en_out, beats_done, busy); end
        repeat (2) tick();
        resetn = 1'b1;
        en_in = 4'b1111;
        tick();
        arm = 1'b1; immediate = 1'b1; sample_count = 32'd0; start_ts = 64'd0;
        set_beat(64'd100, 1'b0, 1'b0);
        tick();
        arm = 1'b0;
        set_beat(64'd101, 1'b1, 1'b1); tick();
        set_beat(64'd102, 1'b1, 1'b1); tick();
        adc_valid = 1'b0;
        n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL rst_pre_run: got %0d required 2", state); end
        @(negedge clk); #1;
        resetn = 1'b0;
        #1;
        n_tests++; if (state !== 3'd0 || fifo_wr_en !== 1'b0 || en_out !== 4'b0) begin
            n_fail++; $display("FAIL rst_midrun: got state=%0d wr_en=%b en=%b required 0/0/0", state, fifo_wr_en, en_out); end
        exp_q.delete();
        tick();
        resetn = 1'b1;
        tick();
        n_tests++; if (state !== 3'd0 || en_out !== 4'b1111) begin
            n_fail++; $display("FAIL rst_release: got state=%0d en=%b required 0/1111", state, en_out); end
    endtask

    task automatic test_timed_start();
        int seen0;
        logic pass;
        en_in = 4'b0101;
        tick();
        n_tests++; if (en_out !== 4'b0101) begin n_fail++; $display("FAIL ts_en_idle: got %b required 0101", en_out); end
        arm = 1'b1; immediate = 1'b0; start_ts = 64'd1000; sample_count = 32'd8;
        set_beat(64'd989, 1'b0, 1'b0);
        tick();
        arm = 1'b0;
        seen0 = n_seen;
        n_tests++; if (state !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL ts_armed: got state=%0d busy=%b required 1/1", state, busy); end
        for (int i = 0; i < 23; i++) begin
            pass = (990 + i >= 1000) && (990 + i < 1008);
            set_beat(64'(990 + i), 1'b1, pass);
            tick();
            n_tests++; if (fifo_wr_en !== pass) begin n_fail++; $display("FAIL ts_gate_%0d: got %b required %b", 990 + i, fifo_wr_en, pass); end
        end
        adc_valid = 1'b0;
        tick();
        n_tests++; if (n_seen - seen0 != 8) begin n_fail++; $display("FAIL ts_beat_count: got %0d required 8", n_seen - seen0); end
        n_tests++; if (done !== 1'b1 || state !== 3'd3 || beats_done !== 32'd8 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ts_done: got done=%b state=%0d beats=%0d busy=%b required 1/3/8/0", done, state, beats_done, busy); end
    endtask

    task automatic test_enable_freeze();
        en_in = 4'b1111;
        tick();
        n_tests++; if (en_out !== 4'b1111) begin n_fail++; $display("FAIL ef_done_load: got %b required 1111", en_out); end
        arm = 1'b1; immediate = 1'b1; sample_count = 32'd5;
        set_beat(64'd2000, 1'b0, 1'b0);
        tick();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en_in = i[0] ? 4'b0011 : 4'b1100;
            set_beat(64'(2001 + i), 1'b1, 1'b1);
            tick();
            n_tests++; if (en_out !== 4'b1111) begin n_fail++; $display("FAIL ef_frozen_%0d: got %b required 1111", i, en_out); end
        end
        adc_valid = 1'b0;
        en_in = 4'b0110;
        n_tests++; if (done !== 1'b1 || beats_done !== 32'd5) begin n_fail++; $display("FAIL ef_done: got done=%b beats=%0d required 1/5", done, beats_done); end
        tick();
        n_tests++; if (en_out !== 4'b0110) begin n_fail++; $display("FAIL ef_follow: got %b required 0110", en_out); end
    endtask

    task automatic test_overflow();
        en_in = 4'b0001;
        fifo_wr_overflow = 1'b1;
        tick();
        fifo_wr_overflow = 1'b0;
        n_tests++; if (overflow_err !== 1'b0 || state !== 3'd3) begin n_fail++; $display("FAIL ov_outside_run: got err=%b state=%0d required 0/3", overflow_err, state); end
        arm = 1'b1; immediate = 1'b1; sample_count = 32'd10;
        set_beat(64'd3000, 1'b0, 1'b0);
        tick();
        arm = 1'b0;
        set_beat(64'd3001, 1'b1, 1'b1); tick();
        set_beat(64'd3002, 1'b1, 1'b1); tick();
        set_beat(64'd3003, 1'b1, 1'b1);
        fifo_wr_overflow = 1'b1;
        tick();
        fifo_wr_overflow = 1'b0;
        n_tests++; if (state !== 3'd4 || overflow_err !== 1'b1 || beats_done !== 32'd3 || fifo_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL ov_error: got state=%0d err=%b beats=%0d wr_en=%b required 4/1/3/1", state, overflow_err, beats_done, fifo_wr_en); end
        set_beat(64'd3004, 1'b1, 1'b0);
        tick();
        n_tests++; if (fifo_wr_en !== 1'b0 || beats_done !== 32'd3) begin n_fail++; $display("FAIL ov_no_beat: got wr_en=%b beats=%0d required 0/3", fifo_wr_en, beats_done); end
        adc_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_tests++; if (state !== 3'd0 || overflow_err !== 1'b0) begin n_fail++; $display("FAIL ov_clear: got state=%0d err=%b required 0/0", state, overflow_err); end
    endtask

    task automatic test_count_one();
        en_in = 4'b0010;
        arm = 1'b1; immediate = 1'b0; start_ts = 64'd5000; sample_count = 32'd1;
        set_beat(64'd4990, 1'b0, 1'b0);
        tick();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_beat(64'(4998 + i), 1'b1, (4998 + i) == 5000);
            tick();
        end
        adc_valid = 1'b0;
        n_tests++; if (state !== 3'd3 || beats_done !== 32'd1) begin n_fail++; $display("FAIL c1_done: got state=%0d beats=%0d required 3/1", state, beats_done); end
        arm = 1'b1; clear = 1'b1; immediate = 1'b0; start_ts = 64'hFFFF_0000; sample_count = 32'd3;
        tick();
        arm = 1'b0; clear = 1'b0;
        n_tests++; if (state !== 3'd1 || beats_done !== 32'd0) begin n_fail++; $display("FAIL c1_clear_arm: got state=%0d beats=%0d required 1/0", state, beats_done); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL c1_abort_armed: got %0d required 0", state); end
    endtask

    task automatic test_back_to_back();
        en_in = 4'b1000;
        arm = 1'b1; immediate = 1'b1; sample_count = 32'd0;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 120; i++) begin
            set_beat(64'(6000 + i), 1'b1, 1'b1);
            tick();
        end
        n_tests++; if (state !== 3'd2 || beats_done !== 32'd120) begin n_fail++; $display("FAIL cont_run: got state=%0d beats=%0d required 2/120", state, beats_done); end
        abort = 1'b1; arm = 1'b1;
        set_beat(64'd7000, 1'b1, 1'b0);
        tick();
        abort = 1'b0; arm = 1'b0; adc_valid = 1'b0;
        n_tests++; if (state !== 3'd0 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_arm: got state=%0d wr_en=%b busy=%b required 0/0/0", state, fifo_wr_en, busy); end
    endtask

    task automatic test_config_err();
        en_in = 4'b0000;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_tests++; if (config_err !== 1'b1 || state !== 3'd0) begin n_fail++; $display("FAIL cfg_pulse: got cfg=%b state=%0d required 1/0", config_err, state); end
        tick();
        n_tests++; if (config_err !== 1'b0) begin n_fail++; $display("FAIL cfg_one_cycle: got %b required 0", config_err); end
    endtask

    task automatic test_late_start();
        en_in = 4'b0011;
        arm = 1'b1; immediate = 1'b0; start_ts = 64'd50; sample_count = 32'd2;
        set_beat(64'd60, 1'b0, 1'b0);
        tick();
        arm = 1'b0;
`ifdef TIMESTAMP_CAPTURE_CTRL_LATE_DETECT_EN
        n_tests++; if (state !== 3'd4 || late_err !== 1'b1) begin n_fail++; $display("FAIL late_error: got state=%0d late=%b required 4/1", state, late_err); end
        set_beat(64'd61, 1'b1, 1'b0);
        tick();
        n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL late_no_beat: got %b required 0", fifo_wr_en); end
        adc_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_tests++; if (state !== 3'd0 || late_err !== 1'b0) begin n_fail++; $display("FAIL late_clear: got state=%0d late=%b required 0/0", state, late_err); end
`else
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL late_armed: got %0d required 1", state); end
        set_beat(64'd61, 1'b1, 1'b1);
        tick();
        n_tests++; if (fifo_wr_en !== 1'b1 || state !== 3'd2) begin n_fail++; $display("FAIL late_first_beat: got wr_en=%b state=%0d required 1/2", fifo_wr_en, state); end
        set_beat(64'd62, 1'b1, 1'b1);
        tick();
        adc_valid = 1'b0;
        n_tests++; if (state !== 3'd3 || beats_done !== 32'd2) begin n_fail++; $display("FAIL late_done: got state=%0d beats=%0d required 3/2", state, beats_done); end
`endif
    endtask

    initial begin
        idle_in();
        en_in = 4'b0000; immediate = 1'b0; start_ts = 64'd0; sample_count = 32'd0;
        set_beat(64'd0, 1'b0, 1'b0);
        test_reset();
        test_timed_start();
        test_enable_freeze();
        test_overflow();
        test_count_one();
        test_back_to_back();
        test_config_err();
        test_late_start();
        idle_in();
        repeat (2) tick();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL beats_missing: got %0d outstanding required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
